change_dispense_ctrl: RTL and testbench
=======================================

// Module: change_dispense_ctrl
// PURPOSE
//  Sequences the coin-ejector actuator after a vend: computes change = paid - price and
//  ejects it one coin at a time, largest denomination first (10, 5, 2, 1).
//  Tracks per-denomination coin inventory. Reports underpayment, lack of exact change
//  and actuator timeout.
//  Sits between the vending FSM (start/price/paid) and the ejector hardware (req/ack).
// PARAMETERS
//  W            8     width of price/paid/change (binary dollars)
//  INV_W        6     width of each inventory counter
//  INV_INIT     8     coins per denomination loaded at reset and on refill
//  TIMEOUT_CYC  1000  max clk cycles to wait on each eject_ack edge
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low; all state cleared
//  start      in   1      one-cycle pulse: begin transaction (ignored unless IDLE)
//  price      in   W      product total; sampled on accepted start
//  paid       in   W      amount entered; sampled on accepted start
//  refill     in   1      pulse: set all inventories to INV_INIT (IDLE only, else ignored)
//  eject_ack  in   1      ejector level ack; high = coin released
//  eject_req  out  1      level request to ejector; held until ack rises
//  coin_sel   out  2      00=$1 01=$2 10=$5 11=$10; stable while eject_req high
//  change_rem out  W      change still owed
//  busy       out  1      high in every state except IDLE/DONE/FAULT
//  done       out  1      one-cycle pulse: all change ejected
//  fault      out  1      sticky until next accepted start or reset
//  fault_code out  2      01 underpay, 10 no exact change, 11 ack timeout, 00 none
// BEHAVIOUR
//  Reset values: eject_req=0, coin_sel=00, change_rem=0, busy=0, done=0, fault=0,
//   fault_code=00, all inventories=INV_INIT, state=IDLE.
//  IDLE: start -> latch price/paid, clear fault -> CALC (next cycle). refill -> reload inventories.
//  CALC (1 cycle): paid<price -> FAULT code 01. Else change_rem=paid-price (W bits, no wrap
//   possible); change_rem==0 -> DONE, otherwise -> PICK.
//  PICK (1 cycle): select largest d in {10,5,2,1} with d<=change_rem and inv[d]>0.
//   None -> FAULT code 10 (change_rem keeps remaining owed). Else drive coin_sel -> REQ.
//  REQ: eject_req=1. ack high -> decrement inv[d], change_rem-=d, eject_req=0 -> REL.
//   Ack not high within TIMEOUT_CYC cycles of entering REQ -> FAULT code 11, eject_req=0.
//  REL: wait ack low (same TIMEOUT_CYC limit -> FAULT 11). Then change_rem==0 -> DONE,
//   else -> PICK.
//  DONE: done=1 for exactly one cycle -> IDLE.
//  FAULT: eject_req=0, fault=1. start accepted (same as IDLE) to retry/restart.
//  Greedy with inventory: e.g. change 6, inv[5]=0 -> 2,2,2. Change 3, inv[2]=0, inv[1]=0
//   -> FAULT 10.
//  Inventory never decrements below 0. Decrement occurs only on the ack rising
//   (REQ->REL transition).
//  start while busy: ignored. start and refill in same IDLE cycle: both honoured.
//  Reset mid-eject: eject_req drops asynchronously. Inventory reloads to INV_INIT.
//  Latency: start -> first eject_req = 3 cycles (CALC, PICK, REQ).
//  Zero change -> done 2 cycles after start.
// STRUCTURE
//  vend_pkg (shared): denomination values DEN_1/2/5/10, coin_sel encodings, state
//   encoding localparams, fault code constants (FLT_NONE/UNDERPAY/NOCHANGE/TIMEOUT).
//  Sub-module ack_timer: loadable down-counter from TIMEOUT_CYC-1.
//   Inputs clk, reset, load, en; output expired.
//   Reloaded on entry to REQ and REL.
//  Top: FSM, price/paid/change regs, four INV_W inventory counters, greedy select mux.
// TESTING
//  price=12 paid=30 -> coins 10,5,2,1; done pulse; change_rem 0; inv10/5/2/1 = 7 each.
//  price=15 paid=10 -> fault=1, code 01, no eject_req ever asserted.
//  price=5 paid=5 -> no eject_req; done 2 cycles after start; fault 0.
//  inv[5] drained to 0, change=6 -> coins 2,2,2 then done.
//   Then refill in IDLE -> inv[5]=8.
//  Ack held low -> fault code 11 after TIMEOUT_CYC cycles; eject_req low; inventory unchanged.
//  Reset asserted while eject_req=1 -> all outputs at reset values immediately.
//   A new start afterwards runs normally.

Source files
------------

// File: rtl/change_dispense_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl_pkg
// Shared definitions for the change dispenser:
//   - coin denomination values and their coin_sel encodings
//   - fault code constants reported on fault_code
//   - controller state encoding
//   - den_of(): maps a coin_sel code to its dollar value
// ---------------------------------------------------------------------------
package change_dispense_ctrl_pkg;

    // Denomination values in dollars
    localparam logic [3:0] DEN_1  = 4'd1;
    localparam logic [3:0] DEN_2  = 4'd2;
    localparam logic [3:0] DEN_5  = 4'd5;
    localparam logic [3:0] DEN_10 = 4'd10;

    // coin_sel encodings; also used as the inventory index
    localparam logic [1:0] SEL_1  = 2'b00;
    localparam logic [1:0] SEL_2  = 2'b01;
    localparam logic [1:0] SEL_5  = 2'b10;
    localparam logic [1:0] SEL_10 = 2'b11;

    // Fault codes
    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_UNDERPAY = 2'b01;
    localparam logic [1:0] FLT_NOCHANGE = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_PICK  = 3'd2,
        ST_REQ   = 3'd3,
        ST_REL   = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    function automatic logic [3:0] den_of(input logic [1:0] sel);
        logic [3:0] v;
        case (sel)
            SEL_1:   v = DEN_1;
            SEL_2:   v = DEN_2;
            SEL_5:   v = DEN_5;
            default: v = DEN_10;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl_if
// Bundles the vending-FSM side (start/price/paid/refill, status outputs) and
// the ejector side (eject_req/eject_ack/coin_sel) of the change dispenser.
//   master : the environment (vending FSM + ejector); drives requests/acks
//   slave  : the change_dispense_ctrl block
// Signals:
//   start, refill      pulses from the vending FSM
//   price, paid        W-bit amounts, sampled on accepted start
//   eject_ack          level ack from the ejector
//   eject_req          level request to the ejector
//   coin_sel           denomination being ejected (00=$1 01=$2 10=$5 11=$10)
//   change_rem         change still owed
//   busy, done, fault  status; fault_code qualifies fault
// ---------------------------------------------------------------------------
interface change_dispense_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] price;
    logic [W-1:0] paid;
    logic         refill;
    logic         eject_ack;
    logic         eject_req;
    logic [1:0]   coin_sel;
    logic [W-1:0] change_rem;
    logic         busy;
    logic         done;
    logic         fault;
    logic [1:0]   fault_code;

    modport master (
        output start, price, paid, refill, eject_ack,
        input  eject_req, coin_sel, change_rem, busy, done, fault, fault_code
    );

    modport slave (
        input  start, price, paid, refill, eject_ack,
        output eject_req, coin_sel, change_rem, busy, done, fault, fault_code
    );

endinterface

// File: rtl/change_dispense_ctrl_ack_timer.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl_ack_timer
// Loadable down-counter bounding how long the controller waits on each
// eject_ack edge. load sets the count to TIMEOUT_CYC-1; while en is high the
// count decrements and parks at zero. expired is high when the count is zero,
// so an ack wait started by load sees exactly TIMEOUT_CYC cycles before the
// controller acts on expired.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-low
//   load     reload the counter
//   en       count enable
//   expired  count has reached zero
// ---------------------------------------------------------------------------
module change_dispense_ctrl_ack_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CW'(TIMEOUT_CYC - 1);
        end else if (load) begin
            cnt_q <= CW'(TIMEOUT_CYC - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl
// After a vend, computes change = paid - price and ejects it one coin at a
// time through a req/ack ejector, largest available denomination first
// (10, 5, 2, 1). Keeps a per-denomination coin inventory and reports
// underpayment, lack of exact change and ejector ack timeout.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low; clears all state, reloads inventories
//   bus    change_dispense_ctrl_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module change_dispense_ctrl
    import change_dispense_ctrl_pkg::*;
#(
    parameter int W           = 8,
    parameter int INV_W       = 6,
    parameter int INV_INIT    = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    change_dispense_ctrl_if.slave bus
);

    state_t       state_q, state_d;
    logic [W-1:0] price_q, paid_q, change_q;
    logic [1:0]   sel_q;
    logic [1:0]   fault_code_q;
    logic [INV_W-1:0] inv_q [4];

    logic       accept_start;
    logic       pick_ok;
    logic [1:0] pick_sel;
    logic       tmr_load, tmr_en, tmr_expired;
    logic       eject_req_c, busy_c, done_c, fault_c;

    // start is honoured from IDLE and also from FAULT (retry/restart)
    assign accept_start = bus.start && ((state_q == ST_IDLE) || (state_q == ST_FAULT));

    // Greedy choice: largest denomination that fits and is still in stock
    always_comb begin
        pick_ok  = 1'b1;
        pick_sel = SEL_1;
        if ((inv_q[SEL_10] != '0) && (change_q >= W'(DEN_10))) begin
            pick_sel = SEL_10;
        end else if ((inv_q[SEL_5] != '0) && (change_q >= W'(DEN_5))) begin
            pick_sel = SEL_5;
        end else if ((inv_q[SEL_2] != '0) && (change_q >= W'(DEN_2))) begin
            pick_sel = SEL_2;
        end else if ((inv_q[SEL_1] != '0) && (change_q >= W'(DEN_1))) begin
            pick_sel = SEL_1;
        end else begin
            pick_ok = 1'b0;
        end
    end

    change_dispense_ctrl_ack_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ack_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs. The timer is loaded on the
    // transitions into REQ and REL so each ack edge gets a fresh window.
    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        eject_req_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        fault_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_start) state_d = ST_CALC;
            end
            ST_CALC: begin
                busy_c = 1'b1;
                if (paid_q < price_q)       state_d = ST_FAULT;
                else if (paid_q == price_q) state_d = ST_DONE;
                else                        state_d = ST_PICK;
            end
            ST_PICK: begin
                busy_c = 1'b1;
                if (pick_ok) begin
                    state_d  = ST_REQ;
                    tmr_load = 1'b1;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_REQ: begin
                busy_c      = 1'b1;
                eject_req_c = 1'b1;
                tmr_en      = 1'b1;
                if (bus.eject_ack) begin
                    state_d  = ST_REL;
                    tmr_load = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_REL: begin
                busy_c = 1'b1;
                tmr_en = 1'b1;
                if (!bus.eject_ack) begin
                    state_d = (change_q == '0) ? ST_DONE : ST_PICK;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                fault_c = 1'b1;
                if (accept_start) state_d = ST_CALC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Transaction datapath, fault code and inventory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            price_q      <= '0;
            paid_q       <= '0;
            change_q     <= '0;
            sel_q        <= SEL_1;
            fault_code_q <= FLT_NONE;
            for (int i = 0; i < 4; i++) inv_q[i] <= INV_W'(INV_INIT);
        end else begin
            if (accept_start) begin
                price_q      <= bus.price;
                paid_q       <= bus.paid;
                fault_code_q <= FLT_NONE;
            end
            if ((state_q == ST_IDLE) && bus.refill) begin
                for (int i = 0; i < 4; i++) inv_q[i] <= INV_W'(INV_INIT);
            end
            case (state_q)
                ST_CALC: begin
                    if (paid_q < price_q) begin
                        fault_code_q <= FLT_UNDERPAY;
                        change_q     <= '0;
                    end else begin
                        change_q <= paid_q - price_q;
                    end
                end
                ST_PICK: begin
                    if (pick_ok) sel_q <= pick_sel;
                    else         fault_code_q <= FLT_NOCHANGE;
                end
                ST_REQ: begin
                    if (bus.eject_ack) begin
                        // Coin released: debit stock and the amount owed
                        if (inv_q[sel_q] != '0) inv_q[sel_q] <= inv_q[sel_q] - INV_W'(1);
                        change_q <= change_q - W'(den_of(sel_q));
                    end else if (tmr_expired) begin
                        fault_code_q <= FLT_TIMEOUT;
                    end
                end
                ST_REL: begin
                    if (bus.eject_ack && tmr_expired) fault_code_q <= FLT_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    assign bus.eject_req  = eject_req_c;
    assign bus.coin_sel   = sel_q;
    assign bus.change_rem = change_q;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.fault      = fault_c;
    assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
module tb_change_dispense_ctrl;

    localparam int W        = 8;
    localparam int INV_INIT = 8;
    localparam int TIMEOUT  = 40;

    logic clk;
    logic reset;

    change_dispense_ctrl_if #(.W(W)) bus ();

    change_dispense_ctrl #(
        .W(W), .INV_W(6), .INV_INIT(INV_INIT), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: coin value per coin_sel code, stock per code
    int vals [4] = '{1, 2, 5, 10};
    int minv [4];
    bit dut_idle;
    int last_coins [$];

    task automatic model_reload();
        for (int i = 0; i < 4; i++) minv[i] = INV_INIT;
    endtask

    task automatic check_inventory(input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(dut.inv_q[i]) !== minv[i]) begin
                errors++;
                $display("FAIL %s inv[$%0d]: got %0d required %0d", name, vals[i], dut.inv_q[i], minv[i]);
            end
        end
    endtask

    // One vend: model the expected greedy result, act as the ejector, compare.
    task automatic do_txn(input int pr, input int pd, input bit hold_ack,
                          input bit poke_start, input bit with_refill, input string name);
        int exp_coins [$];
        int got [$];
        int tinv [4];
        int exp_code, rem, cyc, wait_cnt, rel_wait, first_req, done_cyc, fault_cyc;
        bit saw_req, fault_seen;

        if (with_refill && dut_idle) model_reload();
        tinv = minv;
        exp_code = 0;
        rem = 0;
        if (pd < pr) begin
            exp_code = 1;
        end else begin
            rem = pd - pr;
            while (rem > 0) begin
                int pick = -1;
                for (int c = 3; c >= 0; c--)
                    if (pick < 0 && vals[c] <= rem && tinv[c] > 0) pick = c;
                if (pick < 0) begin
                    exp_code = 2;
                    break;
                end
                exp_coins.push_back(vals[pick]);
                tinv[pick]--;
                rem -= vals[pick];
            end
        end
        if (hold_ack && exp_coins.size() > 0) begin
            exp_code = 3;
            exp_coins.delete();
            rem = pd - pr;
            tinv = minv;
        end

        bus.price  = W'(pr);
        bus.paid   = W'(pd);
        bus.start  = 1'b1;
        bus.refill = with_refill;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.refill = 1'b0;
        cyc = 1;
        wait_cnt = $urandom_range(0, 3);
        rel_wait = 0;
        first_req = -1;
        done_cyc = -1;
        fault_cyc = -1;
        saw_req = 1'b0;
        fault_seen = 1'b0;
        while (cyc < 3000) begin
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            if (bus.fault) begin
                fault_seen = 1'b1;
                fault_cyc = cyc;
                break;
            end
            if (bus.eject_req) begin
                if (!saw_req) begin
                    saw_req = 1'b1;
                    first_req = cyc;
                    checks++;
                    if (bus.busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy_during_eject: got %b required 1", name, bus.busy);
                    end
                end
                if (!bus.eject_ack && !hold_ack) begin
                    if (wait_cnt == 0) begin
                        got.push_back(vals[bus.coin_sel]);
                        bus.eject_ack = 1'b1;
                        rel_wait = $urandom_range(0, 2);
                    end else begin
                        wait_cnt--;
                    end
                end
            end else if (bus.eject_ack) begin
                if (rel_wait == 0) begin
                    bus.eject_ack = 1'b0;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    rel_wait--;
                end
            end
            // A start while busy must be ignored
            if (poke_start && cyc == 2) begin
                bus.start = 1'b1;
                bus.price = W'(0);
                bus.paid  = W'(3);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.eject_ack = 1'b0;
        last_coins = got;

        checks++;
        if (exp_code == 0) begin
            if (done_cyc < 0) begin
                errors++;
                $display("FAIL %s done_seen: got fault=%b code=%0d required done", name, fault_seen, bus.fault_code);
            end
        end else if (!fault_seen || int'(bus.fault_code) !== exp_code) begin
            errors++;
            $display("FAIL %s fault_code: got fault=%b code=%0d required code %0d", name, fault_seen, bus.fault_code, exp_code);
        end

        checks++;
        if (got.size() !== exp_coins.size()) begin
            errors++;
            $display("FAIL %s coin_count: got %0d required %0d", name, got.size(), exp_coins.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_coins[i]) begin
                    errors++;
                    $display("FAIL %s coin[%0d]: got $%0d required $%0d", name, i, got[i], exp_coins[i]);
                end
            end
        end

        if (exp_code != 1) begin
            checks++;
            if (int'(bus.change_rem) !== rem) begin
                errors++;
                $display("FAIL %s change_rem: got %0d required %0d", name, bus.change_rem, rem);
            end
        end

        checks++;
        if (bus.eject_req !== 1'b0) begin
            errors++;
            $display("FAIL %s eject_req_idle: got %b required 0", name, bus.eject_req);
        end

        if (exp_coins.size() > 0 || exp_code == 3) begin
            checks++;
            if (first_req !== 3) begin
                errors++;
                $display("FAIL %s req_latency: got %0d required 3", name, first_req);
            end
        end else begin
            checks++;
            if (saw_req !== 1'b0) begin
                errors++;
                $display("FAIL %s no_req: got eject_req seen required none", name);
            end
        end

        if (exp_code == 0 && exp_coins.size() == 0) begin
            checks++;
            if (done_cyc !== 2) begin
                errors++;
                $display("FAIL %s zero_change_done_latency: got %0d required 2", name, done_cyc);
            end
        end

        if (exp_code == 3) begin
            checks++;
            if (fault_cyc - first_req !== TIMEOUT) begin
                errors++;
                $display("FAIL %s timeout_cycles: got %0d required %0d", name, fault_cyc - first_req, TIMEOUT);
            end
        end

        minv = tinv;
        check_inventory(name);

        if (done_cyc >= 0) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s done_one_cycle: got done=%b busy=%b required 0 0", name, bus.done, bus.busy);
            end
            dut_idle = 1'b1;
        end else begin
            dut_idle = 1'b0;
        end
    endtask

    task automatic do_refill(input string name);
        bus.refill = 1'b1;
        @(posedge clk); #1;
        bus.refill = 1'b0;
        if (dut_idle) model_reload();
        check_inventory(name);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.eject_req !== 1'b0 || bus.coin_sel !== 2'b00 || bus.change_rem !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fault !== 1'b0 || bus.fault_code !== 2'b00) begin
            errors++;
            $display("FAIL %s outputs: got req=%b sel=%b rem=%0d busy=%b done=%b fault=%b code=%b required all zero",
                     name, bus.eject_req, bus.coin_sel, bus.change_rem, bus.busy, bus.done, bus.fault, bus.fault_code);
        end
        model_reload();
        check_inventory(name);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        dut_idle = 1'b1;
    endtask

    task automatic test_basic();
        do_txn(12, 30, 0, 0, 0, "basic_12_30");
        checks++;
        if (last_coins.size() !== 4 || last_coins[0] !== 10 || last_coins[1] !== 5 ||
            last_coins[2] !== 2 || last_coins[3] !== 1) begin
            errors++;
            $display("FAIL basic_sequence: got %0d coins required 10,5,2,1", last_coins.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(dut.inv_q[i]) !== 7) begin
                errors++;
                $display("FAIL basic_inv7[$%0d]: got %0d required 7", vals[i], dut.inv_q[i]);
            end
        end
    endtask

    task automatic test_underpay();
        do_txn(15, 10, 0, 0, 0, "underpay");
        checks++;
        if (bus.fault !== 1'b1 || bus.fault_code !== 2'b01) begin
            errors++;
            $display("FAIL underpay_sticky: got fault=%b code=%b required 1 01", bus.fault, bus.fault_code);
        end
    endtask

    task automatic test_zero_change();
        do_txn(5, 5, 0, 0, 0, "zero_change");
        checks++;
        if (bus.fault !== 1'b0 || bus.fault_code !== 2'b00) begin
            errors++;
            $display("FAIL zero_change_fault: got fault=%b code=%b required 0 00", bus.fault, bus.fault_code);
        end
    endtask

    task automatic test_back_to_back();
        do_txn(0, 8, 0, 1, 0, "start_while_busy");
        do_txn(3, 20, 0, 0, 0, "back_to_back_a");
        do_txn(1, 4, 0, 0, 0, "back_to_back_b");
    endtask

    task automatic test_timeout();
        do_txn(0, 3, 1, 0, 0, "ack_timeout");
        // Retry from FAULT with a working ejector
        do_txn(0, 3, 0, 0, 0, "retry_after_timeout");
    endtask

    task automatic test_reset_mid_eject();
        int n;
        bus.price = W'(0);
        bus.paid  = W'(10);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.eject_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.eject_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_eject_req_seen: got %b required 1", bus.eject_req);
        end
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_eject");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        dut_idle = 1'b1;
        do_txn(0, 10, 0, 0, 0, "after_reset");
    endtask

    task automatic test_drain_five();
        do_refill("drain_refill_pre");
        for (int k = 0; k < INV_INIT; k++) do_txn(0, 5, 0, 0, 0, "drain_five");
        checks++;
        if (dut.inv_q[2] !== '0) begin
            errors++;
            $display("FAIL drained_inv5: got %0d required 0", dut.inv_q[2]);
        end
        do_txn(0, 6, 0, 0, 0, "change6_no_fives");
        checks++;
        if (last_coins.size() !== 3 || last_coins[0] !== 2 || last_coins[1] !== 2 || last_coins[2] !== 2) begin
            errors++;
            $display("FAIL change6_sequence: got %0d coins required 2,2,2", last_coins.size());
        end
        do_refill("refill_after_drain");
        checks++;
        if (int'(dut.inv_q[2]) !== INV_INIT) begin
            errors++;
            $display("FAIL refill_inv5: got %0d required %0d", dut.inv_q[2], INV_INIT);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int pr = $urandom_range(0, 30);
            int pd = $urandom_range(0, 45);
            bit rf = ($urandom_range(0, 3) == 0);
            do_txn(pr, pd, 0, 0, rf, "random");
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.price     = '0;
        bus.paid      = '0;
        bus.refill    = 1'b0;
        bus.eject_ack = 1'b0;
        dut_idle      = 1'b1;
        model_reload();

        test_reset();
        test_basic();
        test_underpay();
        test_zero_change();
        test_back_to_back();
        test_timeout();
        test_reset_mid_eject();
        test_drain_five();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
